// File: rtl/scan_ctrl.sv
// Frame-scan sequencer: clears addr_gen, issues (ag_dim+1)^2 column-major reads, buffers read data
// in a credit-gated output FIFO. Optional macro SCAN_CTRL_STALL_CNT_EN adds the stall_cnt port.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_CLR   | addr_gen sync clear, frame dimension already latched
// S_RUN   | issuing reads, credit-gated
// S_DRAIN | all reads issued, waiting for the last pop
module scan_ctrl #(
    parameter int DW      = 8,
    parameter int RD_LAT  = 2,
    parameter int FIFO_AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [8:0]    img_dim,
    output logic          ag_en,
    output logic          ag_sclr,
    output logic [8:0]    ag_dim,
    input  logic [8:0]    x_cnt,
    input  logic [8:0]    y_cnt,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
`ifdef SCAN_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [8:0]          dim_q, dim_d;
    logic [17:0]         last_idx_q, last_idx_d;
    logic [17:0]         pop_cnt_q, pop_cnt_d;
    logic [CW-1:0]       credit_q, credit_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic [DW-1:0]       mem_q [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       fcnt_q, fcnt_d;
    logic                done_q, done_d;

    logic                issue;
    logic                last_issue;
    logic                push;
    logic                pop;
    logic                last_pop;
    logic [9:0]          dim_p1;
    logic [19:0]         sq;

    // addr_gen clears y at column end whether or not en is high, so that cycle
    // may use the last credit; every other cycle keeps one credit in reserve.
    always_comb begin
        issue = 1'b0;
        if (state_q == S_RUN) begin
            if (y_cnt == dim_q) begin
                issue = (credit_q >= CW'(1));
            end else begin
                issue = (credit_q >= CW'(2));
            end
        end
    end

    assign last_issue = issue && (x_cnt == dim_q) && (y_cnt == dim_q);
    assign push       = vld_q[RD_LAT-1];
    assign pop        = out_valid && out_ready;
    assign last_pop   = pop && (state_q == S_DRAIN) && (pop_cnt_q == last_idx_q);

    assign dim_p1 = {1'b0, dim_q} + 10'd1;
    assign sq     = {10'd0, dim_p1} * {10'd0, dim_p1};

    always_comb begin
        state_d    = state_q;
        dim_d      = dim_q;
        last_idx_d = last_idx_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLR;
                    dim_d   = img_dim;
                end
            end
            S_CLR: begin
                state_d    = S_RUN;
                last_idx_d = 18'(sq - 20'd1);
            end
            S_RUN: begin
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_pop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop_cnt_d = pop ? pop_cnt_q + 18'd1 : pop_cnt_q;
        if (state_q == S_CLR) begin
            pop_cnt_d = 18'd0;
        end
        credit_d = credit_q - CW'(issue) + CW'(pop);
        vld_d    = RD_LAT'({vld_q, issue});
        wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        fcnt_d   = fcnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dim_q      <= 9'd0;
            last_idx_q <= 18'd0;
            pop_cnt_q  <= 18'd0;
            credit_q   <= CW'(DEPTH);
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dim_q      <= dim_d;
            last_idx_q <= last_idx_d;
            pop_cnt_q  <= pop_cnt_d;
            credit_q   <= credit_d;
            vld_q      <= vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
            done_q     <= done_d;
        end
    end

    // Storage is reset so out_data reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= rd_data;
        end
    end

`ifdef SCAN_CTRL_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_CLR) begin
            stall_d = 16'd0;
        end else if ((state_q == S_RUN) && !issue && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign ag_en     = issue;
    assign ag_sclr   = (state_q == S_CLR);
    assign ag_dim    = dim_q;
    assign out_valid = (fcnt_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl: addr_gen and pixel RAM models, table of frame scenarios, plus
// hand-written mid-frame reset sequence.
module tb_scan_ctrl;

    localparam int DW = 8;
    localparam int RD_LAT = 2;
    localparam int FIFO_AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [8:0]    img_dim = 9'd0;
    logic          ag_en, ag_sclr;
    logic [8:0]    ag_dim;
    logic [8:0]    x_cnt = 9'd0;
    logic [8:0]    y_cnt = 9'd0;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy, done;
`ifdef SCAN_CTRL_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int n_checks = 0;
    int n_fail = 0;

    scan_ctrl #(.DW(DW), .RD_LAT(RD_LAT), .FIFO_AW(FIFO_AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .img_dim(img_dim),
        .ag_en(ag_en), .ag_sclr(ag_sclr), .ag_dim(ag_dim),
        .x_cnt(x_cnt), .y_cnt(y_cnt), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
`ifdef SCAN_CTRL_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // addr_gen model: y clears at column end regardless of en; x advances only on an issued column end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= 9'd0;
            y_cnt <= 9'd0;
        end else if (ag_sclr) begin
            x_cnt <= 9'd0;
            y_cnt <= 9'd0;
        end else if (y_cnt == ag_dim) begin
            y_cnt <= 9'd0;
            if (ag_en) x_cnt <= x_cnt + 9'd1;
        end else if (ag_en) begin
            y_cnt <= y_cnt + 9'd1;
        end
    end

    // pixel RAM model, two-cycle read latency, pixel value = {x[3:0], y[3:0]}
    logic [DW-1:0] ram_p0 = '0;
    logic [DW-1:0] ram_p1 = '0;
    always @(posedge clk) begin
        ram_p0 <= ag_en ? {x_cnt[3:0], y_cnt[3:0]} : 8'hEE;
        ram_p1 <= ram_p0;
    end
    assign rd_data = ram_p1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [8:0] dim;
        bit         rnd;
        int         hold;
        bit         poke;
        int         exp_pix;
        int         exp_hold_iss;
        int         exp_busy;
        int         exp_stall;
    } vec_t;

    task automatic run_frame(input vec_t v);
        int d1 = int'(v.dim) + 1;
        int total = d1 * d1;
        int cyc = 0, pops = 0, issues = 0, busy_cyc = 0, stall_obs = 0;
        int data_err = 0, colend_err = 0, dim_err = 0;
        int last_pop_cyc = -10, done_cyc = -1;
        bit got_done = 1'b0;
        bit in_run;
        int ex;
        @(negedge clk);
        img_dim = v.dim;
        start = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!got_done && cyc < 4000) begin
            if (v.hold > 0 && cyc == v.hold) begin
                chk("hold_issues", issues, v.exp_hold_iss);
                chk("hold_out_valid", out_valid, 1);
                chk("hold_ag_en", ag_en, 0);
            end
            if (cyc < v.hold) out_ready = 1'b0;
            else if (v.rnd) out_ready = ($urandom_range(0, 9) < 3);
            else out_ready = 1'b1;
            if (v.poke && cyc == 5) begin
                start = 1'b1;
                img_dim = v.dim + 9'd2;
            end else begin
                start = 1'b0;
            end
            #1;
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                chk("busy_at_done", busy, 0);
`ifdef SCAN_CTRL_STALL_CNT_EN
                chk("stall_cnt", stall_cnt, stall_obs);
`endif
            end else begin
                if (busy) busy_cyc++;
                if (ag_dim != v.dim) dim_err++;
                in_run = busy && !ag_sclr && (issues < total);
                if (in_run && !ag_en) stall_obs++;
                if (in_run && y_cnt == ag_dim && !ag_en) colend_err++;
                if (ag_en) issues++;
                if (out_valid && out_ready) begin
                    ex = (((pops / d1) & 15) << 4) | ((pops % d1) & 15);
                    if (int'(out_data) != ex) data_err++;
                    pops++;
                    last_pop_cyc = cyc;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        start = 1'b0;
        chk("frame_done", got_done, 1);
        chk("pop_count", pops, v.exp_pix);
        chk("issue_count", issues, v.exp_pix);
        chk("data_errors", data_err, 0);
        chk("colend_skips", colend_err, 0);
        chk("ag_dim_errors", dim_err, 0);
        chk("done_latency", done_cyc, last_pop_cyc + 1);
        if (v.exp_busy >= 0) chk("busy_cycles", busy_cyc, v.exp_busy);
        if (v.exp_stall >= 0) chk("run_stalls", stall_obs, v.exp_stall);
        #1;
        chk("done_pulse_width", done, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ag_en"}, ag_en, 0);
        chk({tag, "_ag_sclr"}, ag_sclr, 0);
        chk({tag, "_ag_dim"}, ag_dim, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
`ifdef SCAN_CTRL_STALL_CNT_EN
        chk({tag, "_stall_cnt"}, stall_cnt, 0);
`endif
    endtask

    vec_t tbl[6];

    initial begin
        //            dim   rnd hold poke pix hold_iss busy stall
        tbl[0] = '{9'd3, 1'b0, 0,  1'b0, 16, 0, 20, 0};
        tbl[1] = '{9'd0, 1'b0, 0,  1'b0, 1,  0, 5,  0};
        tbl[2] = '{9'd7, 1'b0, 30, 1'b0, 64, 8, -1, -1};
        tbl[3] = '{9'd7, 1'b1, 0,  1'b0, 64, 0, -1, -1};
        tbl[4] = '{9'd3, 1'b0, 0,  1'b1, 16, 0, 20, 0};
        tbl[5] = '{9'd3, 1'b0, 20, 1'b0, 16, 8, -1, -1};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i]);
        end

        // mid-frame asynchronous reset, checked before any further clock edge
        @(negedge clk);
        img_dim = 9'd7;
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("midframe_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        @(negedge clk);
        out_ready = 1'b0;
        rst_n = 1'b1;

        run_frame(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
